// File: rtl/mem_access_ctrl.sv
// Memory access controller: single-word stores and 1..16 word burst loads
// against a data memory with a registered (1-cycle) read port.
module mem_access_ctrl #(
    parameter int DSIZE     = 16,
    parameter int MEM_SPACE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [MEM_SPACE-1:0] req_addr,
    input  logic [3:0]           req_len,
    input  logic [DSIZE-1:0]     req_wdata,
    output logic                 rsp_valid,
    output logic [DSIZE-1:0]     rsp_data,
    output logic                 rsp_last,
    output logic                 wr_ack,
    output logic [MEM_SPACE-1:0] mem_address,
    output logic [DSIZE-1:0]     mem_data_in,
    output logic                 mem_write_en,
    input  logic [DSIZE-1:0]     mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic                 req_ready_q, req_ready_d;
    logic [3:0]           len_q, len_d;
    logic [3:0]           iss_cnt_q, iss_cnt_d;
    logic [3:0]           cap_cnt_q, cap_cnt_d;
    logic                 mem_vld_q, mem_vld_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_last_q, rsp_last_d;
    logic [DSIZE-1:0]     rsp_data_q, rsp_data_d;
    logic                 wr_ack_q, wr_ack_d;
    logic [MEM_SPACE-1:0] mem_address_q, mem_address_d;
    logic [DSIZE-1:0]     mem_data_in_q, mem_data_in_d;
    logic                 mem_write_en_q, mem_write_en_d;

    logic iss_done;
    logic cap_done;

    assign iss_done = (iss_cnt_q == len_q);
    assign cap_done = (cap_cnt_q == len_q);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        iss_cnt_d      = iss_cnt_q;
        cap_cnt_d      = cap_cnt_q;
        mem_vld_d      = 1'b0;
        rsp_valid_d    = 1'b0;
        rsp_last_d     = 1'b0;
        rsp_data_d     = rsp_data_q;
        wr_ack_d       = 1'b0;
        mem_address_d  = mem_address_q;
        mem_data_in_d  = mem_data_in_q;
        mem_write_en_d = 1'b0;

        // mem_vld_q marks that mem_data_out holds the next burst word
        if (mem_vld_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = mem_data_out;
            rsp_last_d  = cap_done;
            cap_cnt_d   = cap_cnt_q + 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    mem_address_d = req_addr;
                    if (req_we) begin
                        mem_data_in_d  = req_wdata;
                        mem_write_en_d = 1'b1;
                        state_d        = WRITE;
                    end else begin
                        len_d     = req_len;
                        iss_cnt_d = 4'd0;
                        cap_cnt_d = 4'd0;
                        state_d   = RD_ISSUE;
                    end
                end
            end
            WRITE: begin
                wr_ack_d = 1'b1;
                state_d  = IDLE;
            end
            RD_ISSUE: begin
                mem_vld_d = 1'b1;
                if (iss_done) begin
                    state_d = RD_DRAIN;
                end else begin
                    iss_cnt_d     = iss_cnt_q + 4'd1;
                    mem_address_d = mem_address_q + MEM_SPACE'(1);
                end
            end
            RD_DRAIN: begin
                if (mem_vld_q && cap_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            len_q          <= '0;
            iss_cnt_q      <= '0;
            cap_cnt_q      <= '0;
            mem_vld_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_last_q     <= 1'b0;
            rsp_data_q     <= '0;
            wr_ack_q       <= 1'b0;
            mem_address_q  <= '0;
            mem_data_in_q  <= '0;
            mem_write_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            len_q          <= len_d;
            iss_cnt_q      <= iss_cnt_d;
            cap_cnt_q      <= cap_cnt_d;
            mem_vld_q      <= mem_vld_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_last_q     <= rsp_last_d;
            rsp_data_q     <= rsp_data_d;
            wr_ack_q       <= wr_ack_d;
            mem_address_q  <= mem_address_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_write_en_q <= mem_write_en_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_last     = rsp_last_q;
    assign wr_ack       = wr_ack_q;
    assign mem_address  = mem_address_q;
    assign mem_data_in  = mem_data_in_q;
    assign mem_write_en = mem_write_en_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vectors, random traffic against a
// word-array model, held-valid burst and mid-burst reset sequences.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        wr_ack;
    logic [7:0]  mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_en;
    logic [15:0] mem_data_out;

    logic [15:0] dmem [0:255];
    logic [15:0] ref_mem [0:255];
    bit          preload = 1'b1;
    int          errors = 0;
    int          checks = 0;

    mem_access_ctrl #(.DSIZE(16), .MEM_SPACE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .wr_ack       (wr_ack),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) dmem[k] <= 16'(k);
        end else if (mem_write_en) begin
            dmem[mem_address] <= mem_data_in;
        end
        mem_data_out <= dmem[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string name);
        chk({name, "_rv"}, rsp_valid, 0);
        chk({name, "_last"}, rsp_last, 0);
        chk({name, "_we"}, mem_write_en, 0);
        chk({name, "_ack"}, wr_ack, 0);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] d);
        chk("st_ready", req_ready, 1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_len   = 4'($urandom);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("st_we", mem_write_en, 1);
        chk("st_addr", mem_address, a);
        chk("st_din", mem_data_in, d);
        chk("st_ack_early", wr_ack, 0);
        chk("st_busy", req_ready, 0);
        chk("st_rv", rsp_valid, 0);
        ref_mem[a] = d;
        @(posedge clk);
        @(negedge clk);
        chk("st_we_off", mem_write_en, 0);
        chk("st_ack", wr_ack, 1);
        chk("st_rdy", req_ready, 1);
        chk("st_din_hold", mem_data_in, d);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [3:0] l,
                           input bit hold, input logic [7:0] a2,
                           input logic [3:0] l2,
                           output logic [15:0] first,
                           output logic [15:0] last);
        int          n;
        logic [15:0] exp_q[$];
        n = int'(l) + 1;
        first = 'x;
        last  = 'x;
        for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[8'(a + k)]);
        chk("ld_ready", req_ready, 1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_len   = l;
        req_wdata = 16'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            req_addr  = a2;
            req_len   = l2;
            req_wdata = 16'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        for (int j = 0; j <= n + 1; j++) begin
            if (j > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (j < n) chk("ld_addr", mem_address, 8'(a + j));
            chk("ld_we", mem_write_en, 0);
            if (j >= 2) begin
                chk("ld_valid", rsp_valid, 1);
                chk("ld_data", rsp_data, exp_q[j-2]);
                chk("ld_last", rsp_last, (j == n + 1));
                if (j == 2) first = rsp_data;
                if (j == n + 1) last = rsp_data;
            end else begin
                chk("ld_rv_early", rsp_valid, 0);
                chk("ld_ack", wr_ack, 0);
            end
            chk("ld_rdy", req_ready, (j == n + 1));
        end
    endtask

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [3:0]  len;
        logic [15:0] wdata;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t        vt [5];
    logic [15:0] f, l;

    initial begin
        vt[0] = '{1'b1, 8'h10, 4'd0, 16'hBEEF, 16'h0000, 16'h0000};
        vt[1] = '{1'b0, 8'h04, 4'd3, 16'h0000, 16'h0004, 16'h0007};
        vt[2] = '{1'b0, 8'hFE, 4'd3, 16'h0000, 16'h00FE, 16'h0001};
        vt[3] = '{1'b1, 8'h20, 4'd0, 16'h1234, 16'h0000, 16'h0000};
        vt[4] = '{1'b0, 8'h20, 4'd0, 16'h0000, 16'h1234, 16'h1234};
        for (int k = 0; k < 256; k++) ref_mem[k] = 16'(k);

        @(negedge clk);
        preload = 1'b0;
        idle_chk("rst");
        chk("rst_ready", req_ready, 1);
        chk("rst_addr", mem_address, 0);
        chk("rst_din", mem_data_in, 0);
        chk("rst_rdata", rsp_data, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vt[i]) begin
            if (vt[i].we) begin
                do_store(vt[i].addr, vt[i].wdata);
                chk("vec_mem", dmem[vt[i].addr], vt[i].wdata);
            end else begin
                do_load(vt[i].addr, vt[i].len, 1'b0, 8'h00, 4'd0, f, l);
                chk("vec_first", f, vt[i].exp_first);
                chk("vec_last", l, vt[i].exp_last);
            end
        end

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                @(negedge clk);
                idle_chk("gap");
                chk("gap_ready", req_ready, 1);
            end
            if ($urandom_range(0, 1) == 1)
                do_store(8'($urandom), 16'($urandom));
            else
                do_load(8'($urandom), 4'($urandom), 1'b0, 8'h00, 4'd0, f, l);
        end

        do_load(8'h30, 4'd15, 1'b1, 8'h80, 4'd1, f, l);
        do_load(8'h80, 4'd1, 1'b0, 8'h00, 4'd0, f, l);
        chk("hold_second", f, ref_mem[8'h80]);

        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h40;
        req_len   = 4'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_rv3", rsp_valid, 1);
        chk("abort_d3", rsp_data, ref_mem[8'h42]);
        rst = 1'b0;
        #1;
        idle_chk("abort");
        chk("abort_ready", req_ready, 1);
        chk("abort_addr", mem_address, 0);
        chk("abort_din", mem_data_in, 0);
        chk("abort_rdata", rsp_data, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            @(negedge clk);
            idle_chk("post_abort");
        end
        do_load(8'h40, 4'd7, 1'b0, 8'h00, 4'd0, f, l);
        chk("abort_reload", l, ref_mem[8'h47]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
